// File: rtl/dma_block_mover_pkg.sv
// Shared definitions for the DMA block mover: word width, default block
// length in beats, address width and the controller state encoding.
package dma_block_mover_pkg;

  localparam int WORD_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int DMA_BEATS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } dma_state_t;

  // Beats are whole 32-bit words, so the base address must be word aligned.
  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dma_block_mover.sv
// DMA block mover: moves one BEATS x 32-bit block between a wide block port
// and a single-beat memory interface, one outstanding beat at a time.
// Misaligned bases, memory errors and ack timeouts abort into DONE with a
// sticky error flag that is cleared by the next accepted start.
module dma_block_mover
  import dma_block_mover_pkg::*;
#(
  parameter int unsigned BEATS   = DMA_BEATS,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      dma_rx_start,
  input  logic [ADDR_W-1:0]         dma_rx_address,
  output logic [BEATS*WORD_W-1:0]   dma_rx_data,
  input  logic                      dma_tx_start,
  input  logic [ADDR_W-1:0]         dma_tx_address,
  input  logic [BEATS*WORD_W-1:0]   dma_tx_data,
  output logic                      dma_done,
  output logic                      dma_idle,
  output logic                      dma_error,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic                      mem_err,
  input  logic [WORD_W-1:0]         mem_rdata
);

  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BLOCK_W = BEATS * WORD_W;

  dma_state_t          state_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic [TO_W-1:0]     timeout_cnt_reg;
  logic [BLOCK_W-1:0]  tx_shift_reg;
  logic [WORD_W-1:0]   rx_word_reg [BEATS];

  logic                start_any;
  logic                start_rd;
  logic [ADDR_W-1:0]   start_addr;
  logic                last_beat;
  logic                timeout_hit;
  logic                rd_beat_ack;

  // rx wins when both starts arrive together.
  assign start_any   = dma_rx_start | dma_tx_start;
  assign start_rd    = dma_rx_start;
  assign start_addr  = dma_rx_start ? dma_rx_address : dma_tx_address;
  assign last_beat   = (beat_cnt_reg == BEAT_W'(BEATS - 1));
  // A zero TIMEOUT disables the watchdog entirely.
  assign timeout_hit = (TIMEOUT != 0) && (timeout_cnt_reg == TO_W'(TIMEOUT - 1));
  // An ack alongside mem_err is not a successful beat.
  assign rd_beat_ack = (state_reg == ST_RD) && mem_ack && !mem_err;

  // Controller FSM: sequences beats and drives all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      dma_idle        <= 1'b1;
      dma_done        <= 1'b0;
      dma_error       <= 1'b0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      beat_cnt_reg    <= '0;
      timeout_cnt_reg <= '0;
      tx_shift_reg    <= '0;
    end else begin
      dma_done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_any) begin
            dma_idle        <= 1'b0;
            dma_error       <= !is_word_aligned(start_addr);
            beat_cnt_reg    <= '0;
            timeout_cnt_reg <= '0;
            if (!is_word_aligned(start_addr)) begin
              // No beats are issued for a misaligned base.
              state_reg <= ST_DONE;
              dma_done  <= 1'b1;
            end else begin
              state_reg    <= start_rd ? ST_RD : ST_WR;
              mem_req      <= 1'b1;
              mem_we       <= !start_rd;
              mem_addr     <= start_addr;
              mem_wdata    <= start_rd ? '0 : dma_tx_data[WORD_W-1:0];
              tx_shift_reg <= dma_tx_data >> WORD_W;
            end
          end
        end
        ST_RD, ST_WR: begin
          if (mem_err || (!mem_ack && timeout_hit)) begin
            state_reg <= ST_DONE;
            dma_done  <= 1'b1;
            dma_error <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
          end else if (mem_ack) begin
            timeout_cnt_reg <= '0;
            if (last_beat) begin
              state_reg <= ST_DONE;
              dma_done  <= 1'b1;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
            end else begin
              // The next beat is presented in the cycle after the ack.
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
              mem_addr     <= mem_addr + 32'd4;
              mem_wdata    <= (state_reg == ST_WR) ? tx_shift_reg[WORD_W-1:0] : '0;
              tx_shift_reg <= tx_shift_reg >> WORD_W;
            end
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          dma_idle  <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          dma_idle  <= 1'b1;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < int'(BEATS); gi++) begin : g_rx_word
    // Capture read beat gi into its own word slot of the block.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        rx_word_reg[gi] <= '0;
      end else if (rd_beat_ack && (beat_cnt_reg == BEAT_W'(gi))) begin
        rx_word_reg[gi] <= mem_rdata;
      end
    end
  end

  // Word 0 is the least significant word of the block.
  always_comb begin
    dma_rx_data = '0;
    for (int i = 0; i < int'(BEATS); i++) begin
      dma_rx_data[i*WORD_W +: WORD_W] = rx_word_reg[i];
    end
  end

endmodule
